conc_drain: RTL and testbench

CONC_DRAIN -- requirements
Module: conc_drain

---
 rtl/conc_pkg.sv | 15 +
 rtl/byte_fifo.sv | 58 +++++
 rtl/conc_drain.sv | 120 ++++++++++++
 tb/tb_conc_drain.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/conc_pkg.sv
// ============================================================================
// Module   : conc_pkg
// Brief    : Shared widths, default depth and pop-size threshold for conc_drain.
// Revision : 1.0
// ============================================================================
`default_nettype none

package conc_pkg;
    localparam int BYTE_W      = 8;
    localparam int WORD_W      = 16;
    localparam int DEPTH_DEF   = 8;
    localparam int EXTRA_SPACE = 4;
endpackage

`default_nettype wire

// File: rtl/byte_fifo.sv
// ============================================================================
// Module   : byte_fifo
// Brief    : Byte FIFO accepting 0/1/2 pushes and 0/1 pop per cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module byte_fifo
    import conc_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             i_push_cnt,
    input  logic [BYTE_W-1:0]      i_push_d0,
    input  logic [BYTE_W-1:0]      i_push_d1,
    input  logic                   i_pop,
    output logic [BYTE_W-1:0]      o_head,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic [AW-1:0]     w_wr_ptr1;
    logic              w_pop_ok;

    assign w_wr_ptr1 = r_wr_ptr + AW'(1);
    assign w_pop_ok  = i_pop & (r_level != '0);

    always_ff @(posedge clk) begin
        if (i_push_cnt != 2'd0) r_mem[r_wr_ptr]  <= i_push_d0;
        if (i_push_cnt == 2'd2) r_mem[w_wr_ptr1] <= i_push_d1;
    end

    // Pointers are AW bits wide, so wrap modulo DEPTH is implicit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(i_push_cnt);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop_ok);
            r_level  <= r_level + LW'(i_push_cnt) - LW'(w_pop_ok);
        end
    end

    assign o_head  = (r_level != '0) ? r_mem[r_rd_ptr] : '0;
    assign o_level = r_level;

endmodule

`default_nettype wire

// File: rtl/conc_drain.sv
// ============================================================================
// Module   : conc_drain
// Brief    : Drains 1/2-byte queue words into a byte stream with drop tracking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module conc_drain
    import conc_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter bit DROP_ZERO = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WORD_W-1:0]      top_conc,
    output logic                   extra_out,
    output logic [BYTE_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [7:0]             drop_cnt
);
    localparam int            LW      = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] c_DEPTH = LW'(DEPTH);
    localparam logic [LW-1:0] c_SPACE = LW'(EXTRA_SPACE);

    logic              r_mode_q;
    logic              r_vld_q;
    logic              r_extra;
    logic              r_overflow;
    logic [7:0]        r_drop_cnt;

    logic              w_pop;
    logic              w_a_ok;
    logic              w_b_ok;
    logic [LW-1:0]     w_free;
    logic [LW-1:0]     w_level_next;
    logic [1:0]        w_push_cnt;
    logic [BYTE_W-1:0] w_d0;
    logic [1:0]        w_drop;
    logic [8:0]        w_drop_sum;

    assign out_valid = (level != '0);
    assign w_pop     = out_valid & out_ready;

    // Zero bytes are padding: discarded silently, never counted as drops.
    assign w_a_ok = r_vld_q & ~(DROP_ZERO && (top_conc[15:8] == '0));
    assign w_b_ok = r_vld_q & r_mode_q & ~(DROP_ZERO && (top_conc[7:0] == '0));
    assign w_free = c_DEPTH - level + LW'(w_pop);

    // When space is short, the later byte (B) is the one sacrificed.
    always_comb begin
        w_push_cnt = 2'd0;
        w_d0       = top_conc[15:8];
        w_drop     = 2'd0;
        unique case ({w_a_ok, w_b_ok})
            2'b11: begin
                if (w_free >= LW'(2)) begin
                    w_push_cnt = 2'd2;
                end else if (w_free == LW'(1)) begin
                    w_push_cnt = 2'd1;
                    w_drop     = 2'd1;
                end else begin
                    w_drop     = 2'd2;
                end
            end
            2'b10: begin
                if (w_free != '0) w_push_cnt = 2'd1;
                else              w_drop     = 2'd1;
            end
            2'b01: begin
                w_d0 = top_conc[7:0];
                if (w_free != '0) w_push_cnt = 2'd1;
                else              w_drop     = 2'd1;
            end
            default: ;
        endcase
    end

    assign w_level_next = level + LW'(w_push_cnt) - LW'(w_pop);
    assign w_drop_sum   = {1'b0, r_drop_cnt} + {7'b0, w_drop};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_q   <= 1'b0;
            r_vld_q    <= 1'b0;
            r_extra    <= 1'b0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_mode_q   <= r_extra;
            r_vld_q    <= 1'b1;
            r_extra    <= ((c_DEPTH - w_level_next) >= c_SPACE);
            r_overflow <= r_overflow | (w_drop != 2'd0);
            r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push_cnt (w_push_cnt),
        .i_push_d0  (w_d0),
        .i_push_d1  (top_conc[7:0]),
        .i_pop      (w_pop),
        .o_head     (out_data),
        .o_level    (level)
    );

    assign extra_out = r_extra;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_conc_drain.sv
// ============================================================================
// Module   : tb_conc_drain
// Brief    : Self-checking bench for conc_drain with a byte scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_conc_drain;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] top_conc;
    logic        extra_out;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  level;
    logic        overflow;
    logic [7:0]  drop_cnt;

    conc_drain dut (
        .clk       (clk),
        .rst       (rst),
        .top_conc  (top_conc),
        .extra_out (extra_out),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] sb[$];
    logic       m_mode, m_vld, m_extra, m_ovf;
    int         m_drop;

    typedef struct {
        logic [15:0] tc;
        logic        rdy;
        logic [3:0]  lvl;
        logic [7:0]  data;
        logic        extra;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic offer(input logic [7:0] b, inout int free, inout int dropped);
        if (b == 8'h00) return;
        if (free > 0) begin
            sb.push_back(b);
            free--;
        end else begin
            dropped++;
        end
    endtask

    // Drives one cycle; checks current outputs, then advances the model one edge.
    task automatic step(input logic [15:0] tc, input logic rdy);
        int free;
        int dropped;
        top_conc  = tc;
        out_ready = rdy;
        #1;
        check("level", 32'(level), 32'(sb.size()));
        check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        check("extra_out", 32'(extra_out), 32'(m_extra));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (sb.size() != 0) begin
            check("out_data", 32'(out_data), 32'(sb[0]));
            if (rdy) void'(sb.pop_front());
        end else begin
            check("out_data_empty", 32'(out_data), 32'h0);
        end
        free    = DEPTH - sb.size();
        dropped = 0;
        if (m_vld) begin
            offer(tc[15:8], free, dropped);
            if (m_mode) offer(tc[7:0], free, dropped);
        end
        m_drop  = (m_drop + dropped > 255) ? 255 : m_drop + dropped;
        m_ovf   = m_ovf | (dropped != 0);
        m_mode  = m_extra;
        m_extra = ((DEPTH - sb.size()) >= 4);
        m_vld   = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        top_conc  = 16'hDEAD;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rst_level", 32'(level), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data", 32'(out_data), 32'h0);
        check("rst_extra", 32'(extra_out), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        sb.delete();
        m_mode  = 1'b0;
        m_vld   = 1'b0;
        m_extra = 1'b0;
        m_ovf   = 1'b0;
        m_drop  = 0;
        rst     = 1'b0;
    endtask

    initial begin
        vec_t vt[6];
        logic [15:0] w;

        rst       = 1'b1;
        top_conc  = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Expected values are the state after each edge.
        vt[0] = '{16'hFFFF, 1'b0, 4'd0, 8'h00, 1'b1};
        vt[1] = '{16'h5C00, 1'b0, 4'd1, 8'h5C, 1'b1};
        vt[2] = '{16'h0000, 1'b1, 4'd0, 8'h00, 1'b1};
        vt[3] = '{16'hA1B2, 1'b1, 4'd2, 8'hA1, 1'b1};
        vt[4] = '{16'h0000, 1'b1, 4'd1, 8'hB2, 1'b1};
        vt[5] = '{16'h0000, 1'b1, 4'd0, 8'h00, 1'b1};
        for (int i = 0; i < 6; i++) begin
            step(vt[i].tc, vt[i].rdy);
            check($sformatf("tbl%0d_level", i), 32'(level), 32'(vt[i].lvl));
            check($sformatf("tbl%0d_data", i), 32'(out_data), 32'(vt[i].data));
            check($sformatf("tbl%0d_extra", i), 32'(extra_out), 32'(vt[i].extra));
            check($sformatf("tbl%0d_drop", i), 32'(drop_cnt), 32'h0);
        end

        // Stalled sink: fill the buffer, then overflow one byte per cycle.
        for (int i = 0; i < 10; i++) begin
            w = {8'(8'h11 + 8'(i * 34)), 8'(8'h22 + 8'(i * 34))};
            step(w, 1'b0);
        end
        check("fill_level", 32'(level), 32'd8);
        check("fill_overflow", 32'(overflow), 32'h1);

        // Full buffer with simultaneous pop and capture.
        step(16'h3344, 1'b1);
        check("full_pop_level", 32'(level), 32'd8);

        // Drain to 5 then reset mid-stream; first post-reset word is ignored.
        for (int i = 0; i < 3; i++) step(16'h0000, 1'b1);
        check("pre_rst_level", 32'(level), 32'd5);
        do_reset();
        step(16'h7777, 1'b0);
        check("post_rst_ignored", 32'(level), 32'd0);

        for (int i = 0; i < 200; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 3) == 0) w[15:8] = 8'h00;
            if ($urandom_range(0, 3) == 0) w[7:0]  = 8'h00;
            step(w, 1'($urandom_range(0, 2) != 0));
        end

        // Saturation of the drop counter.
        for (int i = 0; i < 320; i++) step(16'hEEEE, 1'b0);
        check("sat_drop_cnt", 32'(drop_cnt), 32'd255);
        check("sat_overflow", 32'(overflow), 32'h1);
        do_reset();
        step(16'h0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
